c7bcsr_mtimer: RTL and testbench

Parametrised multi-channel timer CSR block that supersedes the single TCFG/TVAL/TICLR timer in the core CSR file. It provides NCH independent down-counters, each with its own config, init value and pending latch. It adds a per-channel prescaler, a global interrupt mask and a debug freeze input. It sits beside the core CSR file on the same masked CSR read/write bus and drives a combined timer interrupt into ESTAT.IS.TI.

---
 rtl/c7bcsr_mtimer_pkg.sv | 47 ++++
 rtl/c7bcsr_mtimer_if.sv | 21 ++
 rtl/c7bcsr_mtimer_ch.sv | 74 +++++++
 rtl/c7bcsr_mtimer.sv | 81 ++++++++
 tb/tb_c7bcsr_mtimer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/c7bcsr_mtimer_pkg.sv
// Shared CSR defines for the multi-channel timer: register offsets, CFG field
// positions and the prescaler tick-mask helper.
package c7bcsr_mtimer_pkg;

  localparam int MT_REGS_PER_CH = 4;

  // Per-channel register offsets from BASE + 4*c
  localparam int MT_CFG   = 0;
  localparam int MT_INIT  = 1;
  localparam int MT_TVAL  = 2;
  localparam int MT_TICLR = 3;

  // Global register offsets from BASE + 4*NCH
  localparam int MT_IPEND = 0;
  localparam int MT_IMASK = 1;

  localparam int MT_CFG_EN       = 0;
  localparam int MT_CFG_PERIODIC = 1;
  localparam int MT_CFG_PSEL_LSB = 2;
  localparam int MT_CFG_PSEL_MSB = 3;
  localparam int MT_TICLR_CLR    = 0;

  typedef enum logic [1:0] {
    PSEL_DIV1  = 2'd0,
    PSEL_DIV4  = 2'd1,
    PSEL_DIV16 = 2'd2,
    PSEL_DIV64 = 2'd3
  } mt_psel_e;

  // Field order matches the CFG bit layout: [3:2] psel, [1] periodic, [0] en
  typedef struct packed {
    mt_psel_e psel;
    logic     periodic;
    logic     en;
  } mt_cfg_t;

  // Prescaler bits that must all be ones for a tick
  function automatic logic [5:0] mt_psel_mask(mt_psel_e psel);
    case (psel)
      PSEL_DIV1:  return 6'h00;
      PSEL_DIV4:  return 6'h03;
      PSEL_DIV16: return 6'h0f;
      default:    return 6'h3f;
    endcase
  endfunction

endpackage

// File: rtl/c7bcsr_mtimer_if.sv
// Masked CSR read/write bus shared with the core CSR file.
interface c7bcsr_mtimer_if #(
  parameter int AW = 14
);
  logic [AW-1:0] csr_raddr;
  logic [31:0]   csr_rdata;
  logic [AW-1:0] csr_waddr;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_mask;
  logic          csr_wen;

  modport master (
    output csr_raddr, csr_waddr, csr_wdata, csr_mask, csr_wen,
    input  csr_rdata
  );

  modport slave (
    input  csr_raddr, csr_waddr, csr_wdata, csr_mask, csr_wen,
    output csr_rdata
  );
endinterface

// File: rtl/c7bcsr_mtimer_ch.sv
// One timer channel: CFG and INIT registers, 6-bit prescaler, down-counter and
// pending latch. Loads take priority over ticks; an expiry set beats a clear.
module c7bcsr_mtimer_ch
  import c7bcsr_mtimer_pkg::*;
#(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cfg_we,
  input  logic          init_we,
  input  logic          clr,
  input  logic [TW-1:0] wdata,
  input  logic [TW-1:0] mask,
  input  logic          stop,
  output mt_cfg_t       cfg,
  output logic [TW-1:0] init,
  output logic [TW-1:0] cnt,
  output logic          pend
);

  logic [3:0]    cfg_bits;
  logic [3:0]    cfg_m;
  logic [TW-1:0] init_m;
  logic [5:0]    psc;
  logic [5:0]    psc_mask;
  logic          load;
  logic          run;
  logic          tick;
  logic          expire;

  assign cfg_bits = cfg;
  assign cfg_m    = (cfg_bits & ~mask[3:0]) | (wdata[3:0] & mask[3:0]);
  // A CFG-only write reloads from the unchanged INIT
  assign init_m   = init_we ? ((init & ~mask) | (wdata & mask)) : init;

  assign load     = cfg_we | init_we;
  assign run      = cfg.en & ~stop;
  assign psc_mask = mt_psel_mask(cfg.psel);
  assign tick     = run && ((psc & psc_mask) == psc_mask);
  assign expire   = tick && (cnt == TW'(1)) && !load;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg  <= '0;
      init <= '0;
      cnt  <= '0;
      psc  <= '0;
      pend <= 1'b0;
    end else begin
      if (cfg_we) begin
        cfg <= '{psel:     mt_psel_e'(cfg_m[MT_CFG_PSEL_MSB:MT_CFG_PSEL_LSB]),
                 periodic: cfg_m[MT_CFG_PERIODIC],
                 en:       cfg_m[MT_CFG_EN]};
      end
      if (init_we) init <= init_m;

      if (load) begin
        cnt <= init_m;
        psc <= '0;
      end else begin
        if (run) psc <= psc + 6'd1;
        if (expire)                       cnt <= cfg.periodic ? init : '0;
        else if (tick && cnt > TW'(1))    cnt <= cnt - TW'(1);
      end

      if (expire)   pend <= 1'b1;
      else if (clr) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/c7bcsr_mtimer.sv
// Multi-channel timer CSR block: address decode, IMASK register, read mux and
// the combined timer interrupt feeding ESTAT.IS.TI.
module c7bcsr_mtimer
  import c7bcsr_mtimer_pkg::*;
#(
  parameter int            NCH  = 4,
  parameter int            TW   = 32,
  parameter int            AW   = 14,
  parameter logic [AW-1:0] BASE = AW'(14'h060)
) (
  input  logic                clk,
  input  logic                resetn,
  c7bcsr_mtimer_if.slave      csr,
  input  logic                dbg_stop,
  output logic [NCH-1:0]      timer_pend,
  output logic                timer_intr
);

  function automatic logic [AW-1:0] reg_addr(int c, int ofs);
    return BASE + AW'(MT_REGS_PER_CH * c + ofs);
  endfunction

  localparam logic [AW-1:0] A_IPEND = reg_addr(NCH, MT_IPEND);
  localparam logic [AW-1:0] A_IMASK = reg_addr(NCH, MT_IMASK);

  mt_cfg_t [NCH-1:0]          ch_cfg;
  logic    [NCH-1:0][TW-1:0]  ch_init;
  logic    [NCH-1:0][TW-1:0]  ch_cnt;
  logic    [NCH-1:0]          imask;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic cfg_we;
    logic init_we;
    logic clr;

    assign cfg_we  = csr.csr_wen && (csr.csr_waddr == reg_addr(c, MT_CFG));
    assign init_we = csr.csr_wen && (csr.csr_waddr == reg_addr(c, MT_INIT));
    assign clr     = csr.csr_wen && (csr.csr_waddr == reg_addr(c, MT_TICLR)) &&
                     csr.csr_wdata[MT_TICLR_CLR] && csr.csr_mask[MT_TICLR_CLR];

    c7bcsr_mtimer_ch #(.TW(TW)) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .cfg_we  (cfg_we),
      .init_we (init_we),
      .clr     (clr),
      .wdata   (csr.csr_wdata[TW-1:0]),
      .mask    (csr.csr_mask[TW-1:0]),
      .stop    (dbg_stop),
      .cfg     (ch_cfg[c]),
      .init    (ch_init[c]),
      .cnt     (ch_cnt[c]),
      .pend    (timer_pend[c])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      imask <= '0;
    end else if (csr.csr_wen && csr.csr_waddr == A_IMASK) begin
      imask <= (imask & ~csr.csr_mask[NCH-1:0]) |
               (csr.csr_wdata[NCH-1:0] & csr.csr_mask[NCH-1:0]);
    end
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // any path that left csr_rdata unassigned would infer a latch.
  always_comb begin
    csr.csr_rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (csr.csr_raddr == reg_addr(c, MT_CFG))  csr.csr_rdata = 32'(ch_cfg[c]);
      if (csr.csr_raddr == reg_addr(c, MT_INIT)) csr.csr_rdata = 32'(ch_init[c]);
      if (csr.csr_raddr == reg_addr(c, MT_TVAL)) csr.csr_rdata = 32'(ch_cnt[c]);
    end
    if (csr.csr_raddr == A_IPEND) csr.csr_rdata = 32'(timer_pend);
    if (csr.csr_raddr == A_IMASK) csr.csr_rdata = 32'(imask);
  end

  assign timer_intr = |(timer_pend & imask);

endmodule

// File: tb/tb_c7bcsr_mtimer.sv
// Directed bench for c7bcsr_mtimer: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_c7bcsr_mtimer;

  localparam int            NCH  = 4;
  localparam logic [13:0]   BASE = 14'h060;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             dbg_stop = 1'b0;
  logic [NCH-1:0]   timer_pend;
  logic             timer_intr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  c7bcsr_mtimer_if #(.AW(14)) csr ();

  c7bcsr_mtimer #(.NCH(NCH), .TW(32), .AW(14), .BASE(BASE)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr        (csr),
    .dbg_stop   (dbg_stop),
    .timer_pend (timer_pend),
    .timer_intr (timer_intr)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ra(int c, int ofs);
    return BASE + 14'(4 * c + ofs);
  endfunction

  localparam logic [13:0] A_IPEND = BASE + 14'd16;
  localparam logic [13:0] A_IMASK = BASE + 14'd17;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [13:0] addr, input logic [31:0] data,
                    input logic [31:0] mask = 32'hffff_ffff);
    csr.csr_waddr = addr;
    csr.csr_wdata = data;
    csr.csr_mask  = mask;
    csr.csr_wen   = 1'b1;
    step(1);
    csr.csr_wen   = 1'b0;
  endtask

  task automatic rd(input logic [13:0] addr, output logic [31:0] data);
    csr.csr_raddr = addr;
    #1;
    data = csr.csr_rdata;
  endtask

  task automatic expect_push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag: tag, exp: exp});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic exp_rd(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    expect_push(tag, exp);
    rd(addr, d);
    check(d);
  endtask

  task automatic exp_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_push(tag, exp);
    check(obs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] seen;
    csr.csr_raddr = '0;
    csr.csr_waddr = '0;
    csr.csr_wdata = '0;
    csr.csr_mask  = '0;
    csr.csr_wen   = 1'b0;

    // Reset state
    step(2);
    resetn = 1'b1;
    step(1);
    exp_rd("rst_cfg0", ra(0, 0), 32'd0);
    exp_rd("rst_tval0", ra(0, 2), 32'd0);
    exp_rd("rst_imask", A_IMASK, 32'd0);
    exp_val("rst_pend", 32'(timer_pend), 32'd0);
    exp_val("rst_intr", 32'(timer_intr), 32'd0);

    // 1: asynchronous reset mid-count
    wr(ra(0, 1), 32'd100);
    wr(ra(0, 0), 32'h1);
    step(38);
    exp_rd("t1_tval_running", ra(0, 2), 32'd62);
    resetn = 1'b0;
    #1;
    exp_rd("t1_tval_async", ra(0, 2), 32'd0);
    exp_rd("t1_cfg_async", ra(0, 0), 32'd0);
    exp_val("t1_pend_async", 32'(timer_pend), 32'd0);
    exp_val("t1_intr_async", 32'(timer_intr), 32'd0);
    step(1);
    resetn = 1'b1;
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      seen |= timer_pend;
    end
    exp_val("t1_no_pend_200", 32'(seen), 32'd0);

    // 2: one-shot, interrupt latency, TICLR masking
    wr(ra(1, 1), 32'd5);
    wr(A_IMASK, 32'h2);
    wr(ra(1, 0), 32'h1);
    exp_rd("t2_ipend_start", A_IPEND, 32'd0);
    step(4);
    exp_val("t2_pend1_early", 32'(timer_pend[1]), 32'd0);
    step(1);
    exp_val("t2_pend1_at5", 32'(timer_pend[1]), 32'd1);
    exp_val("t2_intr_at5", 32'(timer_intr), 32'd1);
    exp_rd("t2_ipend_at5", A_IPEND, 32'h2);
    exp_rd("t2_tval1_zero", ra(1, 2), 32'd0);
    step(10);
    exp_rd("t2_tval1_stays", ra(1, 2), 32'd0);
    exp_rd("t2_cfg1_en_kept", ra(1, 0), 32'h1);
    exp_rd("t2_ticlr_reads0", ra(1, 3), 32'd0);
    exp_rd("t2_unmapped_lo", BASE - 14'd1, 32'd0);
    exp_rd("t2_unmapped_hi", A_IMASK + 14'd1, 32'd0);
    wr(ra(1, 3), 32'h1, 32'hffff_fffe);
    exp_val("t2_masked_clr_ignored", 32'(timer_pend[1]), 32'd1);
    wr(ra(1, 3), 32'h1, 32'h1);
    exp_val("t2_pend1_cleared", 32'(timer_pend[1]), 32'd0);
    exp_val("t2_intr_cleared", 32'(timer_intr), 32'd0);
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      seen |= timer_pend;
    end
    exp_val("t2_no_second_pend", 32'(seen), 32'd0);

    // 3: periodic with divide-by-4 prescale; unused CFG bits read 0
    wr(ra(2, 1), 32'd3);
    wr(ra(2, 0), 32'hffff_fff7);
    exp_rd("t3_cfg2_bits", ra(2, 0), 32'h7);
    exp_rd("t3_tval_3", ra(2, 2), 32'd3);
    step(4);
    exp_rd("t3_tval_2", ra(2, 2), 32'd2);
    step(4);
    exp_rd("t3_tval_1", ra(2, 2), 32'd1);
    step(3);
    exp_val("t3_pend2_e11", 32'(timer_pend[2]), 32'd0);
    step(1);
    exp_val("t3_pend2_e12", 32'(timer_pend[2]), 32'd1);
    exp_rd("t3_tval_reload", ra(2, 2), 32'd3);
    exp_val("t3_intr_masked", 32'(timer_intr), 32'd0);
    wr(ra(2, 3), 32'h1);
    exp_val("t3_pend2_clr", 32'(timer_pend[2]), 32'd0);
    step(10);
    exp_val("t3_pend2_e23", 32'(timer_pend[2]), 32'd0);
    step(1);
    exp_val("t3_pend2_e24", 32'(timer_pend[2]), 32'd1);
    wr(ra(2, 0), 32'h0);
    wr(ra(2, 3), 32'h1);
    exp_val("t3_pend2_off", 32'(timer_pend[2]), 32'd0);

    // 4: TICLR colliding with expiry, then one cycle later
    wr(ra(0, 1), 32'd4);
    wr(ra(0, 0), 32'h1);
    step(3);
    wr(ra(0, 3), 32'h1);
    exp_val("t4_set_wins", 32'(timer_pend[0]), 32'd1);
    wr(ra(0, 3), 32'h1);
    exp_val("t4_clr_later", 32'(timer_pend[0]), 32'd0);

    // 5: INIT rewrite in the expiry tick cycle suppresses the expiry
    wr(ra(3, 1), 32'd2);
    wr(ra(3, 0), 32'h1);
    step(1);
    wr(ra(3, 1), 32'd10);
    exp_val("t5_no_pend3", 32'(timer_pend[3]), 32'd0);
    exp_rd("t5_tval3_reload", ra(3, 2), 32'd10);
    step(1);
    exp_rd("t5_tval3_counts", ra(3, 2), 32'd9);
    wr(ra(3, 0), 32'h0);

    // 6: debug freeze delays expiry by exactly the frozen cycles
    wr(ra(0, 1), 32'd8);
    step(2);
    dbg_stop = 1'b1;
    step(5);
    exp_rd("t6_tval0_frozen", ra(0, 2), 32'd6);
    wr(A_IMASK, 32'h1, 32'h1);
    exp_rd("t6_imask_write", A_IMASK, 32'h3);
    step(14);
    dbg_stop = 1'b0;
    exp_rd("t6_tval0_still", ra(0, 2), 32'd6);
    step(5);
    exp_val("t6_pend0_e27", 32'(timer_pend[0]), 32'd0);
    exp_val("t6_intr_e27", 32'(timer_intr), 32'd0);
    step(1);
    exp_val("t6_pend0_e28", 32'(timer_pend[0]), 32'd1);
    exp_val("t6_intr_e28", 32'(timer_intr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
